// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_mux
//  Description : Time-multiplexed driver for N_DIGITS common-anode
//                seven-segment digits that share one segment bus. Digit
//                values, decimal points and enables are held in shadow
//                registers. Each digit gets a fixed slot of SCAN_DIV cycles:
//                BLANK_CYCLES with all anodes off, then the rest with the
//                digit shown. The block decodes hex internally and supports
//                leading-zero suppression.
//
//  Ports       : CLK          system clock, rising edge
//                RST_N        asynchronous active-low reset
//                DATA         hex nibble per digit, digit k = DATA[4k+3:4k]
//                DP_IN        per-digit decimal point request (active-high)
//                EN           per-digit enable (active-high)
//                UPDATE       load strobe for the shadow registers
//                LZ_SUPPRESS  blank leading zeros when 1
//                AN           anode selects (active-low)
//                SS_LED       segments a..g on bits 0..6 (active-low)
//                DP           decimal point (active-low)
//                DIGIT_IDX    index of the current slot
//
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scan_mux #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  wire logic                    CLK,
    input  wire logic                    RST_N,
    input  wire logic [4*N_DIGITS-1:0]   DATA,
    input  wire logic [N_DIGITS-1:0]     DP_IN,
    input  wire logic [N_DIGITS-1:0]     EN,
    input  wire logic                    UPDATE,
    input  wire logic                    LZ_SUPPRESS,
    output logic      [N_DIGITS-1:0]     AN,
    output logic      [6:0]              SS_LED,
    output logic                         DP,
    output logic      [2:0]              DIGIT_IDX
);

    localparam int c_show_cycles = SCAN_DIV - BLANK_CYCLES;
    localparam int c_cnt_w       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    localparam logic [6:0] c_seg_off = 7'h7F;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [2:0]              r_idx;
    logic [N_DIGITS-1:0]     r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [4*N_DIGITS-1:0]   r_sh_data;
    logic [N_DIGITS-1:0]     r_sh_dp;
    logic [N_DIGITS-1:0]     r_sh_en;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                    w_blank_done;
    logic                    w_show_done;
    logic [2:0]              w_idx_nxt;
    logic [N_DIGITS-1:0]     w_supp;
    logic                    w_zero_above;
    logic [3:0]              w_sel_nib;
    logic                    w_sel_en;
    logic                    w_sel_dp;
    logic                    w_sel_supp;
    logic [N_DIGITS-1:0]     w_an_sel;
    logic [N_DIGITS-1:0]     w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_blank_done = (r_state == c_st_blank) &&
                          (r_cnt == c_cnt_w'(BLANK_CYCLES - 1));
    assign w_show_done  = (r_state == c_st_show) &&
                          (r_cnt == c_cnt_w'(c_show_cycles - 1));

    // With a single digit the index simply stays at zero.
    assign w_idx_nxt = (r_idx == 3'(N_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;

    // Leading-zero scan from the most significant digit down. A digit is
    // suppressed while no enabled digit above it holds a nonzero nibble;
    // disabled digits do not stop the run of leading zeros.
    always_comb begin
        w_zero_above = 1'b1;
        w_supp       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            w_supp[k] = LZ_SUPPRESS && (k != 0) &&
                        (r_sh_data[4*k +: 4] == 4'h0) && w_zero_above;
            if (r_sh_en[k] && (r_sh_data[4*k +: 4] != 4'h0)) begin
                w_zero_above = 1'b0;
            end
        end
    end

    // Pick the attributes of the digit whose slot is current.
    always_comb begin
        w_sel_nib  = 4'h0;
        w_sel_en   = 1'b0;
        w_sel_dp   = 1'b0;
        w_sel_supp = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == 3'(k)) begin
                w_sel_nib  = r_sh_data[4*k +: 4];
                w_sel_en   = r_sh_en[k];
                w_sel_dp   = r_sh_dp[k];
                w_sel_supp = w_supp[k];
            end
        end
    end

    assign w_an_sel = ~(N_DIGITS'(1) << r_idx);

    // Outputs latched on the edge that enters SHOW. A suppressed leading
    // zero still lights its anode when its decimal point is requested.
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = c_seg_off;
        w_dp_nxt  = 1'b1;
        if (w_sel_en) begin
            if (w_sel_supp) begin
                if (w_sel_dp) begin
                    w_an_nxt = w_an_sel;
                    w_dp_nxt = 1'b0;
                end
            end else begin
                w_an_nxt  = w_an_sel;
                w_seg_nxt = f_hex_to_seg(w_sel_nib);
                w_dp_nxt  = ~w_sel_dp;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow registers, scan state machine and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= c_st_blank;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_an      <= '1;
            r_seg     <= c_seg_off;
            r_dp      <= 1'b1;
            r_sh_data <= '0;
            r_sh_dp   <= '0;
            r_sh_en   <= '1;
        end else begin
            if (UPDATE) begin
                r_sh_data <= DATA;
                r_sh_dp   <= DP_IN;
                r_sh_en   <= EN;
            end

            case (r_state)
                c_st_blank: begin
                    if (w_blank_done) begin
                        r_state <= c_st_show;
                        r_cnt   <= '0;
                        r_an    <= w_an_nxt;
                        r_seg   <= w_seg_nxt;
                        r_dp    <= w_dp_nxt;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_show: begin
                    if (w_show_done) begin
                        r_state <= c_st_blank;
                        r_cnt   <= '0;
                        r_idx   <= w_idx_nxt;
                        r_an    <= '1;
                        r_seg   <= c_seg_off;
                        r_dp    <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_blank;
                    r_cnt   <= '0;
                    r_an    <= '1;
                    r_seg   <= c_seg_off;
                    r_dp    <= 1'b1;
                end
            endcase
        end
    end

    assign AN        = r_an;
    assign SS_LED    = r_seg;
    assign DP        = r_dp;
    assign DIGIT_IDX = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_mux
//  Description : Self-checking bench for seven_seg_scan_mux with four digits,
//                an 8-cycle slot and a 2-cycle blank. A reference model
//                derives the expected outputs of every cycle from the elapsed
//                cycle count since reset and the shadow contents sampled at
//                the start of each SHOW phase; a monitor compares them with
//                the DUT on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_mux;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BL = 2;

    logic            CLK;
    logic            RST_N;
    logic [4*N-1:0]  DATA;
    logic [N-1:0]    DP_IN;
    logic [N-1:0]    EN;
    logic            UPDATE;
    logic            LZ_SUPPRESS;
    logic [N-1:0]    AN;
    logic [6:0]      SS_LED;
    logic            DP;
    logic [2:0]      DIGIT_IDX;

    seven_seg_scan_mux #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .DATA        (DATA),
        .DP_IN       (DP_IN),
        .EN          (EN),
        .UPDATE      (UPDATE),
        .LZ_SUPPRESS (LZ_SUPPRESS),
        .AN          (AN),
        .SS_LED      (SS_LED),
        .DP          (DP),
        .DIGIT_IDX   (DIGIT_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic [2:0]   idx;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int             m_k;          // edges since reset release
    logic [4*N-1:0] m_data;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_en;
    exp_t           m_show;

    function automatic exp_t show_value(input int d, input logic [4*N-1:0] data,
                                        input logic [N-1:0] dpv, input logic [N-1:0] en,
                                        input logic lz);
        exp_t r;
        logic [3:0] nib;
        bit supp;
        nib   = data[4*d +: 4];
        supp  = lz && (d != 0) && (nib == 4'h0);
        for (int j = d + 1; j < N; j++)
            if (en[j] && data[4*j +: 4] != 4'h0) supp = 1'b0;
        r.an  = '1;
        r.seg = 7'h7F;
        r.dp  = 1'b1;
        r.idx = 3'(d);
        if (en[d]) begin
            if (!supp) begin
                r.an[d] = 1'b0;
                r.seg   = seg_tab[nib];
                r.dp    = ~dpv[d];
            end else if (dpv[d]) begin
                r.an[d] = 1'b0;
                r.dp    = 1'b0;
            end
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        exp_t e;
        int   w;
        if (!RST_N) begin
            m_k    = 0;
            m_data = '0;
            m_dp   = '0;
            m_en   = '1;
            e      = '{an: '1, seg: 7'h7F, dp: 1'b1, idx: 3'd0};
        end else begin
            m_k = m_k + 1;
            w   = m_k % SD;
            if (w == BL)
                m_show = show_value((m_k / SD) % N, m_data, m_dp, m_en, LZ_SUPPRESS);
            if (UPDATE) begin
                m_data = DATA;
                m_dp   = DP_IN;
                m_en   = EN;
            end
            if (w >= BL) begin
                e = m_show;
            end else begin
                e = '{an: '1, seg: 7'h7F, dp: 1'b1, idx: 3'(0)};
            end
            e.idx = 3'((m_k / SD) % N);
        end
        q_exp.push_back(e);
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge CLK) begin
        exp_t e;
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL no_expected got an=%h seg=%h dp=%b idx=%0d", AN, SS_LED, DP, DIGIT_IDX);
        end else begin
            e = q_exp.pop_front();
            if ({AN, SS_LED, DP, DIGIT_IDX} !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL outputs t=%0t got an=%h seg=%h dp=%b idx=%0d exp an=%h seg=%h dp=%b idx=%0d",
                             $time, AN, SS_LED, DP, DIGIT_IDX, e.an, e.seg, e.dp, e.idx);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic do_update(input logic [4*N-1:0] d, input logic [N-1:0] p,
                             input logic [N-1:0] en, input logic lz, input int hold);
        @(negedge CLK);
        DATA        = d;
        DP_IN       = p;
        EN          = en;
        LZ_SUPPRESS = lz;
        UPDATE      = 1'b1;
        repeat (hold) @(negedge CLK);
        UPDATE      = 1'b0;
    endtask

    task automatic wait_show(input int digit, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (DIGIT_IDX == 3'(digit) && AN != '1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_show digit=%0d got none required lit slot", digit);
        end
    endtask

    initial begin
        bit found;
        logic [4*N-1:0] rd;
        RST_N       = 1'b0;
        UPDATE      = 1'b0;
        DATA        = '0;
        DP_IN       = '0;
        EN          = '1;
        LZ_SUPPRESS = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (40) @(negedge CLK);

        do_update(16'h1A3F, 4'b0100, 4'hF, 1'b0, 1);
        repeat (40) @(negedge CLK);
        do_update(16'h0070, 4'b0000, 4'hF, 1'b1, 1);
        repeat (40) @(negedge CLK);
        do_update(16'h0000, 4'b0000, 4'hF, 1'b1, 1);
        repeat (40) @(negedge CLK);
        do_update(16'h0000, 4'b0100, 4'hF, 1'b1, 1);
        repeat (40) @(negedge CLK);
        do_update(16'h8888, 4'b0000, 4'b0101, 1'b0, 1);
        repeat (40) @(negedge CLK);

        // Mid-slot reload: digit 0 must hold its segments until slot end.
        do_update(16'h1234, 4'b0000, 4'hF, 1'b0, 1);
        wait_show(0, found);
        repeat (2) @(negedge CLK);
        do_update(16'h5555, 4'b0000, 4'hF, 1'b0, 1);
        repeat (40) @(negedge CLK);

        // Asynchronous reset in the middle of digit 2's SHOW phase.
        wait_show(2, found);
        if (found) begin
            #2 RST_N = 1'b0;
            #1;
            checks++;
            if (AN !== '1 || SS_LED !== 7'h7F || DP !== 1'b1 || DIGIT_IDX !== 3'd0) begin
                errors++;
                $display("FAIL async_reset got an=%h seg=%h dp=%b idx=%0d required an=f seg=7f dp=1 idx=0",
                         AN, SS_LED, DP, DIGIT_IDX);
            end
            @(negedge CLK);
            RST_N = 1'b1;
        end
        repeat (40) @(negedge CLK);

        // Randomized updates, including multi-cycle UPDATE and stray LZ changes.
        for (int it = 0; it < 150; it++) begin
            for (int j = 0; j < N; j++)
                rd[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            do_update(rd, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), $urandom_range(1, 3));
            repeat ($urandom_range(1, 20)) @(negedge CLK);
            if ($urandom_range(0, 3) == 0) LZ_SUPPRESS = ~LZ_SUPPRESS;
            DATA = 16'($urandom);
        end

        repeat (2) @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
